spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI mode-0 slave for register access.
// A frame is a 1-bit rw flag, then an address, then a 32-bit data word, sent MSB first.
// Writes are committed when the frame closes. Reads issue a request once the command is in,
// and the returned word is shifted out on MISO during the data phase.
//
// state  | meaning
// S_IDLE | waiting for an armed CS falling edge
// S_CMD  | shifting in the rw flag and the address
// S_DATA | data phase: MOSI shifts in, the read word shifts out on MISO
// S_END  | one cycle: classify the frame, then commit it or flag it
module spi_slave_rx #(
  parameter int FRAME_BITS  = 40,
  parameter int ADDR_BITS   = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 spi_clk_in,
  input  logic                 spi_rst_in,
  input  logic                 spi_clk,
  input  logic                 spi_cs,
  input  logic                 spi_sdi,
  output logic                 spi_sdo,
  output logic                 spi_sdo_oe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 wr_valid,
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [31:0]          rd_data,
  input  logic                 rd_data_valid,
  output logic                 frame_err,
  output logic                 rd_err,
  output logic [15:0]          frame_cnt
);

  localparam logic [6:0] CMD_BITS  = 7'(1 + ADDR_BITS);
  localparam logic [6:0] FRAME_LEN = 7'(FRAME_BITS);
  localparam logic [6:0] CNT_MAX   = 7'd127;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_END} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync, r_flush;
  logic                   r_sclk_d, r_cs_d, r_armed;
  logic [6:0]             r_bit_cnt;
  logic [FRAME_BITS-1:0]  r_rx;
  logic [31:0]            r_tx;
  logic                   r_win_open, r_rd_err_pend;

  logic        w_sclk, w_cs, w_sdi;
  logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic        w_in_frame, w_start, w_cmd_done, w_good;
  logic [31:0] w_tx_src;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  // A fall counts only once CS has been seen high after reset, so the tail of a frame
  // that was cut by reset is not mistaken for a new one.
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  assign w_in_frame  = (r_state == S_CMD) || (r_state == S_DATA);
  assign w_start     = (w_state_nxt == S_CMD) && (r_state != S_CMD);
  assign w_cmd_done  = (r_state == S_CMD) && (w_state_nxt == S_DATA);
  assign w_good      = (r_bit_cnt == FRAME_LEN);
  // A word that arrives in the same cycle as the first shift goes straight to MISO.
  assign w_tx_src    = (r_win_open && rd_data_valid) ? rd_data : r_tx;

  // Synchronize the async SPI pins. r_flush marks when the chains hold real pin values.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_flush     <= '0;
    end else begin
      r_sclk_sync <= SYNC_STAGES'({r_sclk_sync, spi_clk});
      r_cs_sync   <= SYNC_STAGES'({r_cs_sync, spi_cs});
      r_sdi_sync  <= SYNC_STAGES'({r_sdi_sync, spi_sdi});
      r_flush     <= SYNC_STAGES'({r_flush, 1'b1});
    end
  end

  // Delayed copies for edge detection; arm CS once it is seen idle after reset.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) begin
      r_sclk_d   <= 1'b0;
      r_cs_d     <= 1'b1;
      r_armed    <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk;
      r_cs_d     <= w_cs;
      r_armed    <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs);
      spi_sdo_oe <= ~w_cs;
    end
  end

  // FSM state register.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic. A CS rise closes any open frame.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_cs_rise)                   w_state_nxt = S_END;
        else if (r_bit_cnt >= CMD_BITS)  w_state_nxt = S_DATA;
      end
      S_DATA: if (w_cs_rise) w_state_nxt = S_END;
      S_END:  w_state_nxt = w_cs_fall ? S_CMD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive path: count bits up to saturation, shift MOSI in, and issue the read request.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
    end else begin
      rd_req <= 1'b0;
      if (w_start)
        r_bit_cnt <= '0;
      else if (w_in_frame && w_sclk_rise && r_bit_cnt != CNT_MAX)
        r_bit_cnt <= r_bit_cnt + 7'd1;
      if (w_in_frame && w_sclk_rise)
        r_rx <= {r_rx[FRAME_BITS-2:0], w_sdi};
      if (w_cmd_done && r_rx[ADDR_BITS]) begin
        rd_req  <= 1'b1;
        rd_addr <= r_rx[ADDR_BITS-1:0];
      end
    end
  end

  // Transmit path: latch the read word inside its window, then shift it out on SCLK falls.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) begin
      spi_sdo       <= 1'b0;
      r_tx          <= '0;
      r_win_open    <= 1'b0;
      r_rd_err_pend <= 1'b0;
    end else begin
      if (r_state == S_DATA) begin
        if (w_sclk_fall) begin
          spi_sdo    <= w_tx_src[31];
          r_tx       <= {w_tx_src[30:0], 1'b0};
          r_win_open <= 1'b0;
          if (r_win_open && !rd_data_valid) r_rd_err_pend <= 1'b1;
        end else if (r_win_open && rd_data_valid) begin
          r_tx       <= rd_data;
          r_win_open <= 1'b0;
        end
      end else begin
        spi_sdo    <= 1'b0;
        r_tx       <= '0;
        r_win_open <= 1'b0;
      end
      if (w_cmd_done && r_rx[ADDR_BITS]) r_win_open    <= 1'b1;
      if (w_start)                       r_rd_err_pend <= 1'b0;
    end
  end

  // Frame close: commit a good write, report late read data or a bad length, count good frames.
  always_ff @(posedge spi_clk_in or negedge spi_rst_in) begin
    if (!spi_rst_in) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      rd_err    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_err    <= 1'b0;
      if (r_state == S_END) begin
        if (w_good) begin
          frame_cnt <= frame_cnt + 16'd1;
          if (!r_rx[FRAME_BITS-1]) begin
            wr_valid <= 1'b1;
            wr_addr  <= r_rx[FRAME_BITS-2 -: ADDR_BITS];
            wr_data  <= r_rx[31:0];
          end else if (r_rd_err_pend) begin
            rd_err <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames plus randomized frames checked against a frame-level model.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk, spi_cs, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic [6:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, rd_req, rd_data_valid, frame_err, rd_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  spi_slave_rx #(.FRAME_BITS(40), .ADDR_BITS(7), .SYNC_STAGES(2)) dut (
    .spi_clk_in(clk), .spi_rst_in(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .frame_err(frame_err), .rd_err(rd_err), .frame_cnt(frame_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitors: every cycle a strobe is high counts once.
  int          n_wr = 0, n_rdreq = 0, n_ferr = 0, n_rerr = 0;
  logic [6:0]  mon_rd_addr = '0;
  logic [38:0] wr_log[$];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      n_wr++;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (rd_req === 1'b1) begin
      n_rdreq++;
      mon_rd_addr = rd_addr;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (rd_err === 1'b1)    n_rerr++;
  end

  // User-side read responder: one-cycle rd_data_valid, rsp_delay cycles after rd_req (<0 = never).
  int          rsp_delay = -1;
  logic [31:0] rsp_data  = '0;

  initial begin
    rd_data       = '0;
    rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1 && rsp_delay >= 0) begin
        repeat (rsp_delay) @(negedge clk);
        rd_data       = rsp_data;
        rd_data_valid = 1'b1;
        @(negedge clk);
        rd_data_valid = 1'b0;
        rd_data       = $urandom;
      end
    end
  end

  // Frame-level reference state.
  logic [15:0] exp_fcnt = '0;
  logic [6:0]  exp_wa   = '0;
  logic [31:0] exp_wd   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI master, mode 0. MISO is sampled just before each rising edge.
  task automatic spi_frame(input logic [39:0] w40, input int nbits, input int h, input int rst_at,
                           input bit cs_last, output logic [63:0] miso, output logic oe_mid);
    miso   = '0;
    oe_mid = 1'b0;
    @(negedge clk);
    spi_clk = 1'b0;
    spi_cs  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = (i < 40) ? w40[39-i] : 1'($urandom);
      repeat (h) @(negedge clk);
      miso = {miso[62:0], spi_sdo};
      if (i == nbits / 2) oe_mid = spi_sdo_oe;
      spi_clk = 1'b1;
      if (cs_last && i == nbits - 1) spi_cs = 1'b1;
      if (i == rst_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (h) @(negedge clk);
      spi_clk = 1'b0;
    end
    if (!cs_last) begin
      repeat (h) @(negedge clk);
      spi_cs = 1'b1;
    end
  endtask

  // One frame plus checks. The read word is latched when it arrives within h-2 cycles of rd_req
  // (the first SCLK fall after the command is seen h cycles after the 8th rise, rd_req 2 cycles after it).
  task automatic do_frame(input string tag, input bit rw, input logic [6:0] addr, input logic [31:0] data,
                          input int nbits, input int h, input int d, input logic [31:0] rsp, input bit cs_last);
    int          wr0, rq0, fe0, re0;
    logic [63:0] miso;
    logic        oe;
    bit          good, latched;
    wr0 = n_wr; rq0 = n_rdreq; fe0 = n_ferr; re0 = n_rerr;
    rsp_data  = rsp;
    rsp_delay = d;
    spi_frame({rw, addr, data}, nbits, h, -1, cs_last, miso, oe);
    repeat (12) @(negedge clk);
    rsp_delay = -1;
    good    = (nbits == 40);
    latched = (d >= 0) && (d <= h - 2);
    if (good) begin
      exp_fcnt = exp_fcnt + 16'd1;
      if (!rw) begin
        exp_wa = addr;
        exp_wd = data;
      end
    end
    chk({tag, " wr_valid pulses"}, 64'(n_wr - wr0), 64'(good && !rw));
    chk({tag, " frame_err pulses"}, 64'(n_ferr - fe0), 64'(!good));
    chk({tag, " rd_req pulses"}, 64'(n_rdreq - rq0), 64'(rw && nbits >= 8));
    if (rw && nbits >= 8) chk({tag, " rd_addr"}, 64'(mon_rd_addr), 64'(addr));
    chk({tag, " rd_err pulses"}, 64'(n_rerr - re0), 64'(good && rw && !latched));
    chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_fcnt));
    chk({tag, " wr_addr"}, 64'(wr_addr), 64'(exp_wa));
    chk({tag, " wr_data"}, 64'(wr_data), 64'(exp_wd));
    if (good && !cs_last) chk({tag, " miso word"}, 64'(miso[31:0]), (rw && latched) ? 64'(rsp) : 64'd0);
    chk({tag, " oe mid-frame"}, 64'(oe), 64'd1);
    chk({tag, " oe after frame"}, 64'(spi_sdo_oe), 64'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] miso;
    logic        oe;
    int          wr0, fe0, h, d, nb;
    bit          rw;
    logic [6:0]  a1, a2;
    logic [31:0] d1, d2;

    rst_n   = 1'b0;
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    spi_sdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset strobes", 64'({wr_valid, rd_req, frame_err, rd_err}), 64'd0);
    chk("reset sdo/oe", 64'({spi_sdo, spi_sdo_oe}), 64'd0);
    chk("reset wr regs", 64'({wr_addr, wr_data}), 64'd0);
    chk("reset rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    do_frame("write05", 1'b0, 7'h05, 32'hDEADBEEF, 40, 4, -1, 32'h0, 1'b0);
    do_frame("read12", 1'b1, 7'h12, 32'h0, 40, 4, 1, 32'hA5A50F0F, 1'b0);
    do_frame("read no-valid", 1'b1, 7'h2A, 32'h0, 40, 4, -1, 32'h0, 1'b0);
    do_frame("read on fall", 1'b1, 7'h33, 32'h0, 40, 4, 2, 32'hC3C3_1234, 1'b0);
    do_frame("read too late", 1'b1, 7'h34, 32'h0, 40, 4, 3, 32'hFFFF_FFFF, 1'b0);
    do_frame("short 20", 1'b0, 7'h11, 32'h1111_2222, 20, 4, -1, 32'h0, 1'b0);
    do_frame("long 41", 1'b0, 7'h12, 32'h3333_4444, 41, 4, -1, 32'h0, 1'b0);
    do_frame("saturate 168", 1'b0, 7'h13, 32'h5555_6666, 168, 4, -1, 32'h0, 1'b0);
    do_frame("cs with last rise", 1'b0, 7'h7E, 32'h8000_0001, 40, 4, -1, 32'h0, 1'b1);

    // Back-to-back writes with a 2-cycle CS high gap at SCLK = clk/8.
    a1 = 7'($urandom); d1 = $urandom; a2 = 7'($urandom); d2 = $urandom;
    wr0 = n_wr;
    spi_frame({1'b0, a1, d1}, 40, 4, -1, 1'b0, miso, oe);
    @(negedge clk);
    spi_frame({1'b0, a2, d2}, 40, 4, -1, 1'b0, miso, oe);
    repeat (12) @(negedge clk);
    exp_fcnt = exp_fcnt + 16'd2;
    exp_wa = a2; exp_wd = d2;
    chk("b2b wr_valid pulses", 64'(n_wr - wr0), 64'd2);
    chk("b2b first write", 64'(wr_log[wr_log.size()-2]), 64'({a1, d1}));
    chk("b2b second write", 64'(wr_log[wr_log.size()-1]), 64'({a2, d2}));
    chk("b2b frame_cnt", 64'(frame_cnt), 64'(exp_fcnt));

    for (int k = 0; k < 12; k++) begin
      rw = 1'($urandom_range(0, 1));
      h  = $urandom_range(4, 6);
      d  = $urandom_range(0, 3);
      if (d == 3) d = -1;
      nb = 40;
      if ($urandom_range(0, 4) == 0) begin
        nb = $urandom_range(9, 48);
        if (nb == 40) nb = 39;
      end
      do_frame("random", rw, 7'($urandom), $urandom, nb, h, d, $urandom, 1'b0);
    end

    // Reset during bit 25 of a write; the rest of that frame must be ignored.
    wr0 = n_wr; fe0 = n_ferr;
    spi_frame({1'b0, 7'h44, 32'h1234_5678}, 40, 4, 24, 1'b0, miso, oe);
    repeat (12) @(negedge clk);
    exp_fcnt = '0; exp_wa = '0; exp_wd = '0;
    chk("reset mid-frame wr_valid", 64'(n_wr - wr0), 64'd0);
    chk("reset mid-frame frame_err", 64'(n_ferr - fe0), 64'd0);
    chk("reset mid-frame frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset mid-frame wr_data", 64'(wr_data), 64'd0);
    do_frame("write01 after reset", 1'b0, 7'h01, 32'h0000_0001, 40, 4, -1, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
